arb_rr_8: RTL and testbench

ARB_RR_8 -- requirements
Module: arb_rr_8

---
 rtl/arb_rr_8.sv | 142 ++++++++++++++
 tb/tb_arb_rr_8.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/arb_rr_8.sv
// Eight-way round-robin arbiter with a grant-hold timeout.
// A grant is held until the owner signals DONE, drops its request, or the
// hold timer reaches MAXHOLD. Every release is followed by one zero-grant GAP
// cycle, and the priority pointer then moves to the requester after the one
// just released.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no grant; arbitrate REQ from PTR every cycle
// BUSY  | grant held; count hold cycles, watch DONE/REQ[IDX]/timeout
// GAP   | one zero-grant cycle after a release; arbitrate like IDLE
module arb_rr_8 #(
    parameter int unsigned MAXHOLD = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] REQ,
    input  logic       DONE,
    output logic [7:0] GNT,
    output logic [2:0] IDX,
    output logic       VLD,
    output logic       TMO
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Hold count on which the timeout fires (MAXHOLD = 0 turns it off).
    localparam bit         TO_EN     = (MAXHOLD != 0);
    localparam logic [7:0] HOLD_LAST = 8'((MAXHOLD == 0) ? 0 : MAXHOLD - 1);

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] hcnt_q, hcnt_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] idx_q, idx_d;
    logic       vld_q, vld_d;
    logic       tmo_q, tmo_d;

    logic       win_vld;
    logic [2:0] win_idx;
    logic [2:0] cand;
    logic       timeout;
    logic       owner_req;

    // Round-robin pick: first set REQ bit at or after PTR, wrapping 7->0.
    // Scanning from the far end keeps the closest candidate as the winner.
    always_comb begin
        win_vld = 1'b0;
        win_idx = ptr_q;
        cand    = ptr_q;
        for (int k = 7; k >= 0; k--) begin
            cand = ptr_q + 3'(k);
            if (REQ[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    // Release causes seen by the current owner.
    always_comb begin
        owner_req = REQ[idx_q];
        timeout   = TO_EN && (hcnt_q == HOLD_LAST);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hcnt_d  = hcnt_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        vld_d   = vld_q;
        tmo_d   = 1'b0;
        case (state_q)
            ST_BUSY: begin
                if (DONE || !owner_req || timeout) begin
                    state_d = ST_GAP;
                    gnt_d   = 8'h00;
                    idx_d   = 3'd0;
                    vld_d   = 1'b0;
                    ptr_d   = idx_q + 3'd1;
                    // A timeout only counts as forced if nothing else released the owner.
                    tmo_d   = timeout && !DONE && owner_req;
                end else if (hcnt_q != 8'hFF) begin
                    hcnt_d = hcnt_q + 8'd1;
                end
            end
            ST_IDLE, ST_GAP: begin
                if (win_vld) begin
                    state_d = ST_BUSY;
                    gnt_d   = 8'h01 << win_idx;
                    idx_d   = win_idx;
                    vld_d   = 1'b1;
                    hcnt_d  = 8'd0;
                end else begin
                    state_d = ST_IDLE;
                    gnt_d   = 8'h00;
                    idx_d   = 3'd0;
                    vld_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 8'h00;
                idx_d   = 3'd0;
                vld_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            ptr_q   <= 3'd0;
            hcnt_q  <= 8'd0;
            gnt_q   <= 8'h00;
            idx_q   <= 3'd0;
            vld_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hcnt_q  <= hcnt_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
            tmo_q   <= tmo_d;
        end
    end

    assign GNT = gnt_q;
    assign IDX = idx_q;
    assign VLD = vld_q;
    assign TMO = tmo_q;

endmodule

// File: tb/tb_arb_rr_8.sv
// Bench for arb_rr_8 (MAXHOLD = 4): a reference model tracks the expected
// owner, pointer and hold time; outputs are compared every negedge, and
// directed scenarios also carry literal expectations.
module tb_arb_rr_8;

    localparam int MAXH = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] REQ = 8'h00;
    logic       DONE = 1'b0;
    logic [7:0] GNT;
    logic [2:0] IDX;
    logic       VLD;
    logic       TMO;

    int n_vec = 0;
    int n_err = 0;

    arb_rr_8 #(.MAXHOLD(MAXH)) dut (
        .CLK (CLK),
        .RST (RST),
        .REQ (REQ),
        .DONE(DONE),
        .GNT (GNT),
        .IDX (IDX),
        .VLD (VLD),
        .TMO (TMO)
    );

    always #5 CLK = ~CLK;

    // Reference model: owner = -1 means nobody holds the grant.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;
    bit m_tmo   = 1'b0;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_owner = -1;
            m_ptr   = 0;
            m_hold  = 0;
            m_tmo   = 1'b0;
        end else if (m_owner >= 0) begin
            bit to_hit;
            to_hit = (MAXH != 0) && (m_hold == MAXH - 1);
            if (DONE || !REQ[m_owner] || to_hit) begin
                m_tmo   = to_hit && !DONE && REQ[m_owner];
                m_ptr   = (m_owner + 1) % 8;
                m_owner = -1;
            end else begin
                m_tmo  = 1'b0;
                m_hold = (m_hold < 255) ? m_hold + 1 : 255;
            end
        end else begin
            m_tmo = 1'b0;
            for (int k = 0; k < 8; k++) begin
                if (m_owner < 0 && REQ[(m_ptr + k) % 8]) begin
                    m_owner = (m_ptr + k) % 8;
                    m_hold  = 0;
                end
            end
        end
    end

    task automatic model_check();
        logic [7:0] e_gnt;
        logic [2:0] e_idx;
        logic       e_vld;
        e_gnt = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
        e_idx = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
        e_vld = (m_owner >= 0);
        n_vec++;
        if (GNT !== e_gnt || IDX !== e_idx || VLD !== e_vld || TMO !== m_tmo) begin
            n_err++;
            $display("FAIL model t=%0t: got gnt=%h idx=%0d vld=%b tmo=%b, want gnt=%h idx=%0d vld=%b tmo=%b",
                     $time, GNT, IDX, VLD, TMO, e_gnt, e_idx, e_vld, m_tmo);
        end
    endtask

    task automatic chk(input string name, input logic [7:0] g, input logic [2:0] i,
                       input logic v, input logic t);
        n_vec++;
        if (GNT !== g || IDX !== i || VLD !== v || TMO !== t) begin
            n_err++;
            $display("FAIL %s: got gnt=%h idx=%0d vld=%b tmo=%b, want gnt=%h idx=%0d vld=%b tmo=%b",
                     name, GNT, IDX, VLD, TMO, g, i, v, t);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST  = 1'b1;
        REQ  = 8'h00;
        DONE = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // Directed stream for the per-cycle model comparison: {REQ, DONE}.
    logic [8:0] vec_tab [0:23] = '{
        {8'h00, 1'b1}, {8'h11, 1'b0}, {8'h11, 1'b0}, {8'h11, 1'b1},
        {8'h11, 1'b0}, {8'h11, 1'b0}, {8'hF0, 1'b0}, {8'h0F, 1'b0},
        {8'h0F, 1'b0}, {8'h02, 1'b0}, {8'h06, 1'b0}, {8'h06, 1'b0},
        {8'h04, 1'b0}, {8'h04, 1'b0}, {8'h04, 1'b0}, {8'h04, 1'b0},
        {8'h04, 1'b1}, {8'hC0, 1'b0}, {8'hC0, 1'b0}, {8'h40, 1'b1},
        {8'h80, 1'b0}, {8'h81, 1'b0}, {8'h00, 1'b0}, {8'h00, 1'b1}
    };

    initial begin
        fork
            forever @(negedge CLK) model_check();
            begin
                // Reset state
                RST = 1'b1;
                #12;
                chk("reset_async", 8'h00, 3'd0, 1'b0, 1'b0);
                @(negedge CLK);
                RST = 1'b0;

                // First grant after reset: 1010_0000 -> requester 5
                REQ = 8'hA0;
                @(negedge CLK);
                chk("first_grant", 8'h20, 3'd5, 1'b1, 1'b0);

                // All requesting, DONE once per grant: 0..7,0 with one gap each
                do_reset();
                REQ = 8'hFF;
                for (int g = 0; g < 9; g++) begin
                    @(negedge CLK);
                    chk("rr_grant", 8'h01 << (g % 8), 3'(g % 8), 1'b1, 1'b0);
                    DONE = 1'b1;
                    @(negedge CLK);
                    DONE = 1'b0;
                    chk("rr_gap", 8'h00, 3'd0, 1'b0, 1'b0);
                end

                // Timeout: held exactly 4 cycles, TMO gap, then re-grant 3
                do_reset();
                REQ = 8'h08;
                for (int c = 0; c < 4; c++) begin
                    @(negedge CLK);
                    chk("hold_cycle", 8'h08, 3'd3, 1'b1, 1'b0);
                end
                @(negedge CLK);
                chk("timeout_gap", 8'h00, 3'd0, 1'b0, 1'b1);
                @(negedge CLK);
                chk("timeout_regrant", 8'h08, 3'd3, 1'b1, 1'b0);

                // DONE coincident with the timeout cycle: no TMO
                do_reset();
                REQ = 8'h08;
                repeat (3) @(negedge CLK);
                @(negedge CLK);
                DONE = 1'b1;
                @(negedge CLK);
                DONE = 1'b0;
                chk("done_at_timeout", 8'h00, 3'd0, 1'b0, 1'b0);

                // Requester drop coincident with timeout: no TMO
                do_reset();
                REQ = 8'h08;
                repeat (4) @(negedge CLK);
                REQ = 8'h00;
                @(negedge CLK);
                chk("drop_at_timeout", 8'h00, 3'd0, 1'b0, 1'b0);

                // Pointer wrap 7 -> 0
                do_reset();
                REQ = 8'h80;
                @(negedge CLK);
                chk("grant7", 8'h80, 3'd7, 1'b1, 1'b0);
                REQ  = 8'h81;
                DONE = 1'b1;
                @(negedge CLK);
                DONE = 1'b0;
                chk("wrap_gap", 8'h00, 3'd0, 1'b0, 1'b0);
                @(negedge CLK);
                chk("wrap_grant0", 8'h01, 3'd0, 1'b1, 1'b0);

                // Reset mid-BUSY with pointer advanced, then resume from 0
                do_reset();
                REQ = 8'h04;
                @(negedge CLK);
                DONE = 1'b1;
                @(negedge CLK);
                DONE = 1'b0;
                REQ  = 8'h44;
                @(negedge CLK);
                chk("pre_rst_grant6", 8'h40, 3'd6, 1'b1, 1'b0);
                @(posedge CLK);
                #2;
                RST = 1'b1;
                #1;
                chk("rst_mid_busy", 8'h00, 3'd0, 1'b0, 1'b0);
                @(negedge CLK);
                REQ = 8'h41;
                RST = 1'b0;
                @(negedge CLK);
                chk("post_rst_grant0", 8'h01, 3'd0, 1'b1, 1'b0);

                // Directed stream checked cycle by cycle against the model
                do_reset();
                for (int v = 0; v < 24; v++) begin
                    REQ  = vec_tab[v][8:1];
                    DONE = vec_tab[v][0];
                    @(negedge CLK);
                end
                REQ  = 8'h00;
                DONE = 1'b0;
                repeat (3) @(negedge CLK);

                #1;
                $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
                $finish;
            end
        join
    end

endmodule
